// File: rtl/fp2_mul_arbiter_if.sv
// Bus bundle between fp2_mul_arbiter, its requesters and the shared fp2_mul.
// The slave modport is the arbiter's view; master is the surrounding system.
interface fp2_mul_arbiter_if #(
  parameter int NREQ = 2,
  parameter int W    = 255
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_y_re;
  logic [NREQ*W-1:0] req_y_im;
  logic [NREQ*W-1:0] req_z_re;
  logic [NREQ*W-1:0] req_z_im;
  logic [W-1:0]      mul_y_re;
  logic [W-1:0]      mul_y_im;
  logic [W-1:0]      mul_z_re;
  logic [W-1:0]      mul_z_im;
  logic [W-1:0]      mul_x_re;
  logic [W-1:0]      mul_x_im;
  logic [NREQ-1:0]   rsp_valid;
  logic [W-1:0]      rsp_x_re;
  logic [W-1:0]      rsp_x_im;
  logic              busy;

  modport slave (
    input  req_valid, req_y_re, req_y_im, req_z_re, req_z_im, mul_x_re, mul_x_im,
    output req_ready, mul_y_re, mul_y_im, mul_z_re, mul_z_im, rsp_valid, rsp_x_re, rsp_x_im, busy
  );

  modport master (
    output req_valid, req_y_re, req_y_im, req_z_re, req_z_im, mul_x_re, mul_x_im,
    input  req_ready, mul_y_re, mul_y_im, mul_z_re, mul_z_im, rsp_valid, rsp_x_re, rsp_x_im, busy
  );
endinterface

// File: rtl/fp2_mul_arbiter.sv
// Round-robin, credit-limited sharing of one pipelined fp2_mul among NREQ requesters.
// Define FP2_ARB_STATS_EN to add the stat_issue_cnt / stat_stall_cnt counters.
module fp2_mul_arbiter #(
  parameter int NREQ    = 2,
  parameter int LAT     = 29,
  parameter int MAX_OUT = 32,
  parameter int W       = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  fp2_mul_arbiter_if.slave   bus
`ifdef FP2_ARB_STATS_EN
  ,
  output logic [31:0]        stat_issue_cnt,
  output logic [31:0]        stat_stall_cnt
`endif
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW  = $clog2(MAX_OUT + 1);

  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  grant_id;
  logic [IDW-1:0]  ptr_next;
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] grant;
  logic            accept;
  logic [CW-1:0]   cnt [NREQ];
  logic            cnt_nz;

  // Stage 0 travels with the mul_* registers; stages 1..LAT shadow the
  // multiplier's internal registers, so stage LAT lines up with mul_x_*.
  logic [LAT:0]    tag_v;
  logic [IDW-1:0]  tag_id [LAT+1];
  logic [NREQ-1:0] rsp_onehot;

  logic [W-1:0]    sel_y_re, sel_y_im, sel_z_re, sel_z_im;
  logic [W-1:0]    mul_y_re_q, mul_y_im_q, mul_z_re_q, mul_z_im_q;
  logic [W-1:0]    rsp_x_re_q, rsp_x_im_q;
  logic [NREQ-1:0] rsp_valid_q;

  always_comb begin
    eligible = '0;
    cnt_nz   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      eligible[i] = bus.req_valid[i] && (cnt[i] < CW'(MAX_OUT));
      cnt_nz      = cnt_nz | (cnt[i] != '0);
    end
  end

  always_comb begin
    logic [IDW-1:0] idx;
    idx      = '0;
    grant    = '0;
    grant_id = '0;
    accept   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (!accept && eligible[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = idx;
        accept     = 1'b1;
      end
    end
  end

  always_comb begin
    sel_y_re = '0;
    sel_y_im = '0;
    sel_z_re = '0;
    sel_z_im = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_y_re = bus.req_y_re[i*W +: W];
        sel_y_im = bus.req_y_im[i*W +: W];
        sel_z_re = bus.req_z_re[i*W +: W];
        sel_z_im = bus.req_z_im[i*W +: W];
      end
    end
  end

  always_comb begin
    rsp_onehot = '0;
    rsp_onehot[tag_id[LAT]] = tag_v[LAT];
  end

  assign ptr_next = (int'(grant_id) == NREQ - 1) ? '0 : grant_id + IDW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr         <= '0;
      mul_y_re_q  <= '0;
      mul_y_im_q  <= '0;
      mul_z_re_q  <= '0;
      mul_z_im_q  <= '0;
      tag_v       <= '0;
      rsp_valid_q <= '0;
      rsp_x_re_q  <= '0;
      rsp_x_im_q  <= '0;
      for (int s = 0; s <= LAT; s++) tag_id[s] <= '0;
      for (int i = 0; i < NREQ; i++) cnt[i] <= '0;
    end else begin
      if (accept) begin
        ptr        <= ptr_next;
        mul_y_re_q <= sel_y_re;
        mul_y_im_q <= sel_y_im;
        mul_z_re_q <= sel_z_re;
        mul_z_im_q <= sel_z_im;
      end
      tag_v     <= {tag_v[LAT-1:0], accept};
      tag_id[0] <= grant_id;
      for (int s = 1; s <= LAT; s++) tag_id[s] <= tag_id[s-1];
      rsp_valid_q <= rsp_onehot;
      if (tag_v[LAT]) begin
        rsp_x_re_q <= bus.mul_x_re;
        rsp_x_im_q <= bus.mul_x_im;
      end
      // A same-cycle issue and retire cancel out, leaving the credit count unchanged.
      for (int i = 0; i < NREQ; i++) begin
        if (grant[i] && !rsp_valid_q[i])
          cnt[i] <= cnt[i] + CW'(1);
        else if (!grant[i] && rsp_valid_q[i])
          cnt[i] <= cnt[i] - CW'(1);
      end
    end
  end

`ifdef FP2_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_issue_cnt <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (accept) stat_issue_cnt <= stat_issue_cnt + 32'd1;
      if (|(bus.req_valid & ~grant)) stat_stall_cnt <= stat_stall_cnt + 32'd1;
    end
  end
`endif

  assign bus.req_ready = grant;
  assign bus.mul_y_re  = mul_y_re_q;
  assign bus.mul_y_im  = mul_y_im_q;
  assign bus.mul_z_re  = mul_z_re_q;
  assign bus.mul_z_im  = mul_z_im_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_x_re  = rsp_x_re_q;
  assign bus.rsp_x_im  = rsp_x_im_q;
  assign bus.busy      = (|tag_v) | cnt_nz;
endmodule

// File: tb/tb_fp2_mul_arbiter.sv
// Self-checking bench for fp2_mul_arbiter: a stand-in LAT-cycle fp2_mul plus a
// queue-based reference model of grants, credits and per-cycle expected responses.
module tb_fp2_mul_arbiter;
  localparam int NREQ    = 2;
  localparam int LAT     = 29;
  localparam int MAX_OUT = 4;
  localparam int W       = 255;

  typedef struct {
    int           t;
    int           id;
    logic [W-1:0] re;
    logic [W-1:0] im;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fp2_mul_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

`ifdef FP2_ARB_STATS_EN
  logic [31:0] stat_issue_cnt;
  logic [31:0] stat_stall_cnt;
`endif

  fp2_mul_arbiter #(.NREQ(NREQ), .LAT(LAT), .MAX_OUT(MAX_OUT), .W(W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus)
`ifdef FP2_ARB_STATS_EN
    ,
    .stat_issue_cnt (stat_issue_cnt),
    .stat_stall_cnt (stat_stall_cnt)
`endif
  );

  // Stand-in multiplier: output in cycle t is the product of the inputs seen in cycle t-LAT.
  logic [W-1:0] pipe_re [LAT];
  logic [W-1:0] pipe_im [LAT];
  always @(posedge clk) begin
    pipe_re[0] <= bus.mul_y_re * bus.mul_z_re - bus.mul_y_im * bus.mul_z_im;
    pipe_im[0] <= bus.mul_y_re * bus.mul_z_im + bus.mul_y_im * bus.mul_z_re;
    for (int s = 1; s < LAT; s++) begin
      pipe_re[s] <= pipe_re[s-1];
      pipe_im[s] <= pipe_im[s-1];
    end
  end
  assign bus.mul_x_re = pipe_re[LAT-1];
  assign bus.mul_x_im = pipe_im[LAT-1];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int mcnt [NREQ];
  int mptr;
  exp_t expq [$];
  logic [W-1:0] op_yr [NREQ];
  logic [W-1:0] op_yi [NREQ];
  logic [W-1:0] op_zr [NREQ];
  logic [W-1:0] op_zi [NREQ];
  logic [W-1:0] m_yr, m_yi, m_zr, m_zi, m_rsp_re, m_rsp_im;
  logic [31:0]  m_issue, m_stall;

  task automatic check_output(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREQ; i++) mcnt[i] = 0;
    mptr = 0;
    expq.delete();
    m_yr = '0; m_yi = '0; m_zr = '0; m_zi = '0;
    m_rsp_re = '0; m_rsp_im = '0;
    m_issue = '0; m_stall = '0;
  endtask

  task automatic set_op(input int i, input logic v, input logic [W-1:0] yr, input logic [W-1:0] yi,
                        input logic [W-1:0] zr, input logic [W-1:0] zi);
    op_yr[i] = yr; op_yi[i] = yi; op_zr[i] = zr; op_zi[i] = zi;
    bus.req_valid[i]         = v;
    bus.req_y_re[i*W +: W]   = yr;
    bus.req_y_im[i*W +: W]   = yi;
    bus.req_z_re[i*W +: W]   = zr;
    bus.req_z_im[i*W +: W]   = zi;
  endtask

  task automatic apply_stimulus(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++)
      set_op(i, v[i], W'($urandom_range(0, 65535)), W'($urandom_range(0, 65535)),
             W'($urandom_range(0, 65535)), W'($urandom_range(0, 65535)));
  endtask

  // One clock cycle: compare everything against the model, then advance the model.
  task automatic tick();
    int g;
    int idx;
    int total;
    logic [NREQ-1:0] exp_ready;
    logic [NREQ-1:0] exp_rv;
    logic exp_busy;
    exp_t e;
    #1;
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      idx = (mptr + k) % NREQ;
      if (g < 0 && bus.req_valid[idx] && mcnt[idx] < MAX_OUT) g = idx;
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    exp_rv = '0;
    if (expq.size() > 0 && expq[0].t == cyc) begin
      e = expq.pop_front();
      exp_rv[e.id] = 1'b1;
      m_rsp_re = e.re;
      m_rsp_im = e.im;
    end
    total = 0;
    for (int i = 0; i < NREQ; i++) total += mcnt[i];
    exp_busy = (total != 0);

    check_output("req_ready", W'(bus.req_ready), W'(exp_ready));
    check_output("rsp_valid", W'(bus.rsp_valid), W'(exp_rv));
    check_output("rsp_x_re", bus.rsp_x_re, m_rsp_re);
    check_output("rsp_x_im", bus.rsp_x_im, m_rsp_im);
    check_output("busy", W'(bus.busy), W'(exp_busy));
    check_output("mul_y_re", bus.mul_y_re, m_yr);
    check_output("mul_y_im", bus.mul_y_im, m_yi);
    check_output("mul_z_re", bus.mul_z_re, m_zr);
    check_output("mul_z_im", bus.mul_z_im, m_zi);
`ifdef FP2_ARB_STATS_EN
    check_output("stat_issue_cnt", W'(stat_issue_cnt), W'(m_issue));
    check_output("stat_stall_cnt", W'(stat_stall_cnt), W'(m_stall));
`endif

    for (int i = 0; i < NREQ; i++) if (exp_rv[i]) mcnt[i]--;
    if (|(bus.req_valid & ~exp_ready)) m_stall++;
    if (g >= 0) begin
      mcnt[g]++;
      mptr = (g + 1) % NREQ;
      m_issue++;
      m_yr = op_yr[g]; m_yi = op_yi[g]; m_zr = op_zr[g]; m_zi = op_zi[g];
      e.t  = cyc + LAT + 2;
      e.id = g;
      e.re = op_yr[g] * op_zr[g] - op_yi[g] * op_zi[g];
      e.im = op_yr[g] * op_zi[g] + op_yi[g] * op_zr[g];
      expq.push_back(e);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    apply_stimulus('0);
    repeat (n) tick();
  endtask

  initial begin
`ifdef FP2_ARB_STATS_EN
    logic [31:0] issue0, stall0;
`endif
    model_reset();
    bus.req_valid = '0;
    bus.req_y_re  = '0;
    bus.req_y_im  = '0;
    bus.req_z_re  = '0;
    bus.req_z_im  = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    $display("[TB] reset released");
    idle(2);

    // Single operation: (3+i)(2+i) = 5+5i
    set_op(0, 1'b1, W'(3), W'(1), W'(2), W'(1));
    tick();
    idle(34);
    check_output("single_rsp_re_const", bus.rsp_x_re, W'(5));
    check_output("single_rsp_im_const", bus.rsp_x_im, W'(5));

    // Contention: both requesters valid for six cycles
`ifdef FP2_ARB_STATS_EN
    issue0 = stat_issue_cnt;
    stall0 = stat_stall_cnt;
`endif
    repeat (6) begin
      apply_stimulus(2'b11);
      tick();
    end
    apply_stimulus('0);
`ifdef FP2_ARB_STATS_EN
    #1;
    check_output("contention_issue_delta", W'(stat_issue_cnt - issue0), W'(6));
    check_output("contention_stall_delta", W'(stat_stall_cnt - stall0), W'(6));
`endif
    idle(36);

    // Credit limit: requester 0 streams, requester 1 occasionally asks
    for (int n = 0; n < 45; n++) begin
      apply_stimulus({(n % 5 == 2), 1'b1});
      tick();
    end
    idle(40);

    // Issue from requester 0 in the very cycle its previous result retires
    set_op(0, 1'b1, W'(7), W'(2), W'(4), W'(3));
    tick();
    idle(30);
    apply_stimulus(2'b01);
    tick();
    repeat (8) begin
      apply_stimulus(2'b01);
      tick();
    end
    idle(40);

    // Random traffic
    repeat (150) begin
      apply_stimulus(NREQ'($urandom_range(0, (1 << NREQ) - 1)));
      tick();
    end
    idle(40);

    // Asynchronous reset with three operations in flight
    repeat (3) begin
      apply_stimulus(2'b01);
      tick();
    end
    idle(10);
    #2 rst_n = 1'b0;
    #1;
    check_output("reset_rsp_valid", W'(bus.rsp_valid), W'(0));
    check_output("reset_busy", W'(bus.busy), W'(0));
    check_output("reset_mul_y_re", bus.mul_y_re, W'(0));
    check_output("reset_rsp_x_re", bus.rsp_x_re, W'(0));
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(40);
    set_op(0, 1'b1, W'(3), W'(1), W'(2), W'(1));
    tick();
    idle(34);
    check_output("post_reset_rsp_re_const", bus.rsp_x_re, W'(5));
    check_output("post_reset_rsp_im_const", bus.rsp_x_im, W'(5));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
